// File: rtl/matrix_col_shifter.sv
// Captures one gen_line column into a holding buffer, shifts it serially into an
// external LED shift-register chain (ser_clk/ser_dat), then pulses the storage latch.
module matrix_col_shifter #(
  parameter int LINE      = 24,
  parameter int CLK_DIV   = 2,
  parameter int LATCH_W   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [LINE-1:0] col_data,
  input  logic            col_valid,
  output logic            col_ready,
  input  logic            ovr_clr,
  output logic            ser_clk,
  output logic            ser_dat,
  output logic            ser_lat,
  output logic            col_done,
  output logic            busy,
  output logic            overrun,
  output logic [1:0]      dbg_state
);

  // Handshake: a column is taken on any cycle where col_valid && col_ready;
  // col_valid while !col_ready drops the column and sets the sticky overrun flag.

  localparam int BW = $clog2(LINE + 1);
  localparam int DW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int LW = $clog2(LATCH_W + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HI   = DW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(LINE - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LINE-1:0] hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [LINE-1:0] sreg_q, sreg_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            ser_clk_q, ser_clk_d;
  logic            ser_dat_q, ser_dat_d;
  logic            ser_lat_q, ser_lat_d;
  logic            overrun_q, overrun_d;
  logic            load_now;
  logic            accept;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    bitcnt_d    = bitcnt_q;
    div_d       = div_q;
    lat_d       = lat_q;
    ser_dat_d   = ser_dat_q;
    overrun_d   = overrun_q;

    load_now  = (state_q == S_IDLE) && hold_full_q;
    col_ready = !hold_full_q || load_now;
    accept    = col_valid && col_ready;

    // An accept in the load_now cycle refills the buffer the FSM is emptying.
    if (accept) begin
      hold_d      = col_data;
      hold_full_d = 1'b1;
    end else if (load_now) begin
      hold_full_d = 1'b0;
    end

    if (col_valid && !col_ready) overrun_d = 1'b1;
    else if (ovr_clr)            overrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_now) begin
          sreg_d    = hold_q;
          bitcnt_d  = '0;
          div_d     = '0;
          ser_dat_d = MSB_FIRST ? hold_q[LINE-1] : hold_q[0];
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            lat_d   = '0;
            state_d = S_LATCH;
          end else begin
            sreg_d    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            bitcnt_d  = bitcnt_q + 1'b1;
            ser_dat_d = MSB_FIRST ? sreg_d[LINE-1] : sreg_d[0];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (lat_q == LAT_LAST) state_d = S_IDLE;
        else                   lat_d   = lat_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ser_clk_d = (state_d == S_SHIFT) && (div_d >= DIV_HI);
    ser_lat_d = (state_d == S_LATCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      bitcnt_q    <= '0;
      div_q       <= '0;
      lat_q       <= '0;
      ser_clk_q   <= 1'b0;
      ser_dat_q   <= 1'b0;
      ser_lat_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      bitcnt_q    <= bitcnt_d;
      div_q       <= div_d;
      lat_q       <= lat_d;
      ser_clk_q   <= ser_clk_d;
      ser_dat_q   <= ser_dat_d;
      ser_lat_q   <= ser_lat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ser_clk   = ser_clk_q;
  assign ser_dat   = ser_dat_q;
  assign ser_lat   = ser_lat_q;
  assign col_done  = (state_q == S_LATCH) && (lat_q == LAT_LAST);
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
